// File: rtl/ascii_operand_parser_if.sv
// Handshake bundle between a character source / operation sink (master)
// and the ASCII operand parser (slave).
interface ascii_operand_parser_if #(
    parameter int W = 5
);
    logic         ch_valid;
    logic [7:0]   ch_data;
    logic         ch_ready;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c0;
    logic         op_valid;
    logic         op_ready;
    logic         err;

    // Environment side: supplies characters, consumes operations.
    modport master (
        output ch_valid, ch_data, op_ready,
        input  ch_ready, x, y, c0, op_valid, err
    );

    // Parser side.
    modport slave (
        input  ch_valid, ch_data, op_ready,
        output ch_ready, x, y, c0, op_valid, err
    );
endinterface

// File: rtl/ascii_operand_parser.sv
// Byte-serial ASCII parser: two-digit X, two-digit Y, then '+' or '-'.
// Presents binary operands plus add/sub select with a valid/ready handshake.
// Malformed input produces a one-cycle err pulse and restarts at the X tens digit.
module ascii_operand_parser #(
    parameter int W       = 5,
    parameter int MAX_VAL = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    ascii_operand_parser_if.slave bus
);
    typedef enum logic [2:0] {
        ST_XH   = 3'd0,
        ST_XL   = 3'd1,
        ST_YH   = 3'd2,
        ST_YL   = 3'd3,
        ST_OP   = 3'd4,
        ST_HOLD = 3'd5
    } state_t;

    state_t       r_state;
    logic [3:0]   r_tens;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic         r_c0;
    logic         r_op_valid;
    logic         r_err;

    logic         w_take;
    logic         w_is_digit;
    logic         w_is_crlf;
    logic         w_is_plus;
    logic         w_is_minus;
    logic [3:0]   w_digit;
    logic [6:0]   w_value;
    logic         w_in_range;

    // Character classification; the value is formed at 7 bits (max 99).
    assign w_take     = bus.ch_valid & bus.ch_ready;
    assign w_is_digit = (bus.ch_data >= 8'h30) && (bus.ch_data <= 8'h39);
    assign w_is_crlf  = (bus.ch_data == 8'h0D) || (bus.ch_data == 8'h0A);
    assign w_is_plus  = (bus.ch_data == 8'h2B);
    assign w_is_minus = (bus.ch_data == 8'h2D);
    assign w_digit    = bus.ch_data[3:0];
    assign w_value    = ({3'b000, r_tens} * 7'd10) + {3'b000, w_digit};
    assign w_in_range = (w_value <= 7'(MAX_VAL));

    // Outputs: ch_ready is a pure decode of state, everything else is registered.
    assign bus.ch_ready = (r_state != ST_HOLD);
    assign bus.x        = r_x;
    assign bus.y        = r_y;
    assign bus.c0       = r_c0;
    assign bus.op_valid = r_op_valid;
    assign bus.err      = r_err;

    // Parser FSM: digit assembly, operator decode, error recovery and output hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_XH;
            r_tens     <= 4'd0;
            r_x        <= '0;
            r_y        <= '0;
            r_c0       <= 1'b0;
            r_op_valid <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_XH, ST_YH: begin
                    if (w_take) begin
                        if (w_is_digit) begin
                            r_tens  <= w_digit;
                            r_state <= (r_state == ST_XH) ? ST_XL : ST_YL;
                        end else if (!w_is_crlf) begin
                            r_err   <= 1'b1;
                            r_state <= ST_XH;
                        end
                    end
                end
                ST_XL, ST_YL: begin
                    if (w_take) begin
                        if (w_is_digit && w_in_range) begin
                            if (r_state == ST_XL) begin
                                r_x     <= W'(w_value);
                                r_state <= ST_YH;
                            end else begin
                                r_y     <= W'(w_value);
                                r_state <= ST_OP;
                            end
                        end else if (!w_is_crlf) begin
                            // Out-of-range value or non-digit: discard the entry.
                            r_err   <= 1'b1;
                            r_state <= ST_XH;
                        end
                    end
                end
                ST_OP: begin
                    if (w_take) begin
                        if (w_is_plus || w_is_minus) begin
                            r_c0       <= w_is_minus;
                            r_op_valid <= 1'b1;
                            r_state    <= ST_HOLD;
                        end else if (!w_is_crlf) begin
                            r_err   <= 1'b1;
                            r_state <= ST_XH;
                        end
                    end
                end
                ST_HOLD: begin
                    // Operands stay frozen until downstream takes them.
                    if (bus.op_ready) begin
                        r_op_valid <= 1'b0;
                        r_state    <= ST_XH;
                    end
                end
                default: begin
                    r_op_valid <= 1'b0;
                    r_state    <= ST_XH;
                end
            endcase
        end
    end
endmodule

// File: doc/ascii_operand_parser.md
# ascii_operand_parser

Upstream feeder for the 5-bit add/subtract stage. It consumes a byte-serial ASCII character stream (keyboard/UART side) of the form two-digit X, two-digit Y, then an operator character. It assembles the binary operands and the add/subtract select, and presents them to the arithmetic stage with a valid/ready handshake. Malformed input raises a one-cycle error pulse, discards the partial entry and restarts parsing.

## Interface
Parameters:
- W, 5, operand width in bits; must satisfy 2^W > MAX_VAL.
- MAX_VAL, 15, largest legal decimal operand value; must be ≤ 99.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- ch_valid  input  1  ch_data holds a character this cycle.
- ch_data  input  8  ASCII character.
- ch_ready  output  1  parser can accept a character; a byte is taken when ch_valid & ch_ready.
- x  output  W  operand X (binary), stable while op_valid.
- y  output  W  operand Y (binary), stable while op_valid.
- c0  output  1  operation select: 0 = add ('+', 0x2B), 1 = subtract ('-', 0x2D).
- op_valid  output  1  x/y/c0 form a complete operation.
- op_ready  input  1  downstream accepts the operation when op_valid & op_ready.
- err  output  1  one-cycle pulse on a rejected entry.

## Operation
- States: XH (X tens digit), XL (X units digit), YH, YL, OP (operator), HOLD (operation presented).
- Reset state is XH.
- Digits are 0x30–0x39. The value is tens*10 + units, computed when the units digit is accepted. Hold the tens digit in a 4-bit register; compute the value at ≥7 bits, then truncate to W.
- XH, on a digit: store the tens digit, go to XL.
- XL, on a digit: if value ≤ MAX_VAL, load x and go to YH; otherwise raise the error.
- YH and YL: same as XH and XL, loading y.
- OP: '+' sets c0=0, '-' sets c0=1; go to HOLD.
- CR (0x0D) and LF (0x0A) are ignored in XH..OP. Accept them, no state change, no error.
- Any other character in XH..OP is an error. So is a non-operator in OP, or a non-digit in a digit state.
- Error handling:
  - err=1 for exactly one cycle.
  - State returns to XH.
  - x, y and c0 keep their last values and are don't-care.
  - op_valid stays 0.
- A '+' or '-' in XH..YL is an error. Digits in OP are an error.
- HOLD: op_valid=1, ch_ready=0.
  - On op_valid & op_ready: go to XH.
  - Without op_ready: remain in HOLD indefinitely with x, y and c0 frozen.
- ch_ready = (state != HOLD). It is combinational from state and never depends on ch_valid.
- Reset asserted mid-entry or in HOLD: immediately aborts. No err pulse; partial digits are lost.

## Timing
- Reset values:
  - x=0, y=0, c0=0.
  - op_valid=0, err=0.
  - state=XH, so ch_ready=1 while rst is high and after release.
- One character is accepted per cycle maximum. A 5-character entry with no gaps produces op_valid=1 in the cycle after the operator byte's accepting edge (latency 1 clock).
- Ignored CR/LF and ch_valid=0 cycles add no state change.
- err is registered: high in the cycle after the offending byte is accepted. The parser is back in XH with ch_ready=1 in that same cycle, so a new entry may begin immediately.
- Handshake completion:
  - op_valid & op_ready at an edge: op_valid=0 and ch_ready=1 the next cycle.
  - Back-to-back entries therefore need ≥1 idle cycle on ch between the operator and the next X digit.
- op_ready while op_valid=0 is ignored.
- op_valid never drops without op_ready, except on rst.
- Bytes presented while ch_ready=0 are not consumed. The upstream source holds them.

## Test plan
- Stream "07","05","+" back-to-back, op_ready=1 -> op_valid high 1 cycle after '+', x=7, y=5, c0=0; next cycle op_valid=0, ch_ready=1.
- Stream "15","15","-" with op_ready=0 for 3 cycles and ch_valid held with '9' -> op_valid and x=15, y=15, c0=1 frozen; ch_ready=0 throughout; '9' not consumed. Raise op_ready -> one transfer, then '9' is taken as an X tens digit.
- Stream "1","6" -> err pulse 1 cycle after '6'; op_valid stays 0; following "03","02","+" yields x=3, y=2, c0=0.
- Stream "0","A" and separately "04","0","3","*" -> err pulse after 'A' and after '*'; no op_valid.
- Stream "1",LF,"2",CR,"00",LF,"-" -> no err; x=12, y=0, c0=1.
- Assert rst for one cycle after "09","1" -> all outputs at reset values, no err. A subsequent "02","01","+" gives x=2, y=1, c0=0.
